call_stack_seq: RTL and testbench

//  Executes the memory side of JSR/RET. It pushes the 16-bit return address onto a

---
 rtl/arch_defs_pkg.sv | 17 +
 rtl/stack_pointer.sv | 33 +++
 rtl/call_stack_seq.sv | 143 ++++++++++++++
 tb/tb_call_stack_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/arch_defs_pkg.sv
// Shared constants and FSM encoding for the JSR/RET call-stack sequencer.
package arch_defs_pkg;

  localparam logic [7:0] STACK_PAGE = 8'h01;
  localparam logic [7:0] SP_RESET   = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StPushHi,
    StPushLo,
    StPopLo,
    StPopHi,
    StPopWait,
    StDone
  } stack_state_t;

endpackage

// File: rtl/stack_pointer.sv
// Descending stack pointer: modulo-2^WIDTH register with increment/decrement enables.
module stack_pointer #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = arch_defs_pkg::SP_RESET
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] sp,
  output logic [WIDTH-1:0] sp_plus1,
  output logic             wrap_up,
  output logic             wrap_dn
);

  logic [WIDTH-1:0] sp_q;

  assign sp       = sp_q;
  assign sp_plus1 = sp_q + WIDTH'(1);
  assign wrap_up  = inc & (sp_q == '1);
  assign wrap_dn  = dec & (sp_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= RESET_VAL;
    end else if (inc) begin
      sp_q <= sp_plus1;
    end else if (dec) begin
      sp_q <= sp_q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/call_stack_seq.sv
// Memory side of JSR/RET: pushes a return address as two bytes onto a descending
// RAM stack page, or pops it back and presents it for the PC load.
module call_stack_seq #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] STACK_PAGE = arch_defs_pkg::STACK_PAGE,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = arch_defs_pkg::SP_RESET
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_jsr_i,
  input  logic                  op_ret_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] ret_addr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] sp_o,
  output logic                  ovf_o,
  output logic                  unf_o
);

  import arch_defs_pkg::*;

  stack_state_t          state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] ret_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  we_q, re_q, busy_q, done_q, ovf_q, unf_q;

  logic                  sp_inc, sp_dec, wrap_up, wrap_dn;
  logic [DATA_WIDTH-1:0] sp, sp_plus1;

  assign sp_dec = (state_q == StPushHi) || (state_q == StPushLo);
  assign sp_inc = (state_q == StPopLo) || (state_q == StPopHi);

  stack_pointer #(
    .WIDTH     (DATA_WIDTH),
    .RESET_VAL (SP_RESET)
  ) u_sp (
    .clk      (clk),
    .reset    (reset),
    .inc      (sp_inc),
    .dec      (sp_dec),
    .sp       (sp),
    .sp_plus1 (sp_plus1),
    .wrap_up  (wrap_up),
    .wrap_dn  (wrap_dn)
  );

  // Strobes and status are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ret_q   <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ovf_q  <= ovf_q | wrap_dn;
      unf_q  <= unf_q | wrap_up;
      we_q   <= 1'b0;
      re_q   <= 1'b0;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= 1'b0;
          if (op_jsr_i) begin
            pc_q    <= pc_i;
            we_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StPushHi;
          end else if (op_ret_i) begin
            re_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StPopLo;
          end
        end
        StPushHi: begin
          we_q    <= 1'b1;
          state_q <= StPushLo;
        end
        StPushLo: begin
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StPopLo: begin
          re_q    <= 1'b1;
          state_q <= StPopHi;
        end
        StPopHi: begin
          lo_q    <= mem_rdata_i;
          state_q <= StPopWait;
        end
        StPopWait: begin
          ret_q   <= {mem_rdata_i, lo_q};
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Pops address the slot above SP; pushes address SP itself.
  always_comb begin
    mem_addr_o  = {STACK_PAGE, sp};
    mem_wdata_o = '0;
    case (state_q)
      StPushHi:         mem_wdata_o = pc_q[ADDR_WIDTH-1:DATA_WIDTH];
      StPushLo:         mem_wdata_o = pc_q[DATA_WIDTH-1:0];
      StPopLo, StPopHi: mem_addr_o  = {STACK_PAGE, sp_plus1};
      default:          ;
    endcase
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign ret_addr_o = ret_q;
  assign mem_we_o   = we_q;
  assign mem_re_o   = re_q;
  assign sp_o       = sp;
  assign ovf_o      = ovf_q;
  assign unf_o      = unf_q;

endmodule

// File: tb/tb_call_stack_seq.sv
// Directed scoreboard bench for call_stack_seq with a synchronous RAM model.
module tb_call_stack_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_jsr_i, op_ret_i;
  logic [15:0] pc_i;
  logic        busy_o, done_o;
  logic [15:0] ret_addr_o, mem_addr_o;
  logic [7:0]  mem_wdata_o, mem_rdata_i, sp_o;
  logic        mem_we_o, mem_re_o, ovf_o, unf_o;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ram [0:65535];
  logic [7:0]  mram [0:255];
  logic [7:0]  msp;
  logic        movf, munf;
  logic [15:0] last_ret;
  logic [23:0] wq [$];
  logic [15:0] rq [$];
  logic [15:0] retq [$];

  always #5 clk = ~clk;

  call_stack_seq dut (
    .clk         (clk),
    .reset       (reset),
    .op_jsr_i    (op_jsr_i),
    .op_ret_i    (op_ret_i),
    .pc_i        (pc_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ret_addr_o  (ret_addr_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o),
    .mem_re_o    (mem_re_o),
    .mem_rdata_i (mem_rdata_i),
    .sp_o        (sp_o),
    .ovf_o       (ovf_o),
    .unf_o       (unf_o)
  );

  function automatic logic [7:0] seed(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // RAM with 1-cycle read latency; stack page refilled with a known pattern in reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[{8'h01, 8'(i)}] <= seed(8'(i));
      mem_rdata_i <= 8'h00;
    end else begin
      if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
      if (mem_re_o) mem_rdata_i <= ram[mem_addr_o];
    end
  end

  // Bus monitor: every strobe must match the next expected access.
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_we_o && mem_re_o) chk("we_re_overlap", 1, 0);
      if (mem_we_o) begin
        if (wq.size() == 0) chk("unexpected_write", {8'h00, mem_addr_o, mem_wdata_o}, 0);
        else chk("write", {8'h00, mem_addr_o, mem_wdata_o}, {8'h00, wq.pop_front()});
      end
      if (mem_re_o) begin
        if (rq.size() == 0) chk("unexpected_read", {16'h0, mem_addr_o}, 0);
        else chk("read_addr", {16'h0, mem_addr_o}, {16'h0, rq.pop_front()});
      end
    end
  end

  task automatic model_push(input logic [15:0] pc);
    logic [7:0] b [2];
    b[0] = pc[15:8];
    b[1] = pc[7:0];
    for (int i = 0; i < 2; i++) begin
      wq.push_back({8'h01, msp, b[i]});
      mram[msp] = b[i];
      if (msp == 8'h00) movf = 1'b1;
      msp = msp - 8'h01;
    end
  endtask

  task automatic model_pop();
    logic [7:0] lo, hi;
    rq.push_back({8'h01, 8'(msp + 8'h01)});
    lo = mram[8'(msp + 8'h01)];
    if (msp == 8'hFF) munf = 1'b1;
    msp = msp + 8'h01;
    rq.push_back({8'h01, 8'(msp + 8'h01)});
    hi = mram[8'(msp + 8'h01)];
    if (msp == 8'hFF) munf = 1'b1;
    msp = msp + 8'h01;
    retq.push_back({hi, lo});
  endtask

  // Issue one request from IDLE; poke holds op_ret_i high while busy.
  task automatic run_op(input bit jsr, input bit ret, input logic [15:0] pc, input bit poke,
                        input string tag);
    int lat;
    bit is_ret;
    is_ret = !jsr && ret;
    if (jsr) model_push(pc);
    else if (ret) model_pop();
    op_jsr_i = jsr;
    op_ret_i = ret;
    pc_i     = pc;
    @(posedge clk); #1;
    op_jsr_i = 1'b0;
    op_ret_i = poke;
    pc_i     = 16'hDEAD;
    lat = 1;
    while (!done_o && lat < 20) begin
      chk({tag, "_busy"}, busy_o, 1);
      @(posedge clk); #1;
      lat++;
    end
    op_ret_i = 1'b0;
    chk({tag, "_latency"}, lat, is_ret ? 4 : 3);
    chk({tag, "_busy_in_done"}, busy_o, 1);
    if (is_ret && retq.size() != 0) last_ret = retq.pop_front();
    chk({tag, "_ret_addr"}, ret_addr_o, last_ret);
    chk({tag, "_sp"}, sp_o, msp);
    chk({tag, "_ovf"}, ovf_o, movf);
    chk({tag, "_unf"}, unf_o, munf);
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, busy_o, 0);
    chk({tag, "_done_pulse"}, done_o, 0);
    chk({tag, "_writes_left"}, wq.size(), 0);
    chk({tag, "_reads_left"}, rq.size(), 0);
  endtask

  initial begin
    reset    = 1'b1;
    op_jsr_i = 1'b0;
    op_ret_i = 1'b0;
    pc_i     = 16'h0000;
    msp      = 8'hFF;
    movf     = 1'b0;
    munf     = 1'b0;
    last_ret = 16'h0000;
    for (int i = 0; i < 256; i++) mram[i] = seed(8'(i));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_sp", sp_o, 8'hFF);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_unf", unf_o, 0);
    chk("rst_ret", ret_addr_o, 16'h0000);
    chk("rst_we", mem_we_o, 0);
    chk("rst_re", mem_re_o, 0);
    @(posedge clk); #1;

    run_op(1, 0, 16'h1234, 0, "t1_jsr");
    chk("t1_ram01ff", ram[16'h01FF], 8'h12);
    chk("t1_ram01fe", ram[16'h01FE], 8'h34);
    chk("t1_sp_fd", sp_o, 8'hFD);

    run_op(0, 1, 16'h0000, 0, "t2_ret");
    chk("t2_ret_1234", ret_addr_o, 16'h1234);
    chk("t2_sp_ff", sp_o, 8'hFF);

    run_op(1, 0, 16'h0100, 0, "t3_jsr_a");
    run_op(1, 0, 16'h0200, 0, "t3_jsr_b");
    run_op(0, 1, 16'h0000, 0, "t3_ret_b");
    chk("t3_ret_0200", ret_addr_o, 16'h0200);
    run_op(0, 1, 16'h0000, 0, "t3_ret_a");
    chk("t3_ret_0100", ret_addr_o, 16'h0100);
    chk("t3_sp_ff", sp_o, 8'hFF);

    run_op(0, 1, 16'h0000, 0, "t4_ret_empty");
    chk("t4_unf", unf_o, 1);
    chk("t4_sp_01", sp_o, 8'h01);

    run_op(1, 0, 16'hBEEF, 0, "t5_jsr_wrap");
    chk("t5_ovf", ovf_o, 1);
    chk("t5_sp_ff", sp_o, 8'hFF);
    chk("t5_ram0101", ram[16'h0101], 8'hBE);
    chk("t5_ram0100", ram[16'h0100], 8'hEF);

    run_op(1, 1, 16'h5A5A, 0, "t6_both");
    chk("t6_sp_fd", sp_o, 8'hFD);
    run_op(0, 1, 16'h0000, 0, "t6_ret");
    chk("t6_ret_5a5a", ret_addr_o, 16'h5A5A);

    run_op(1, 0, 16'h7777, 1, "t7_jsr_poke");
    run_op(0, 1, 16'h0000, 0, "t7_ret");
    chk("t7_ret_7777", ret_addr_o, 16'h7777);

    // Abort a push in its second byte with an asynchronous reset.
    model_push(16'h4321);
    op_jsr_i = 1'b1;
    pc_i     = 16'h4321;
    @(posedge clk); #1;
    op_jsr_i = 1'b0;
    @(posedge clk); #1;
    chk("t8_we_in_push_lo", mem_we_o, 1);
    chk("t8_wdata_lo", mem_wdata_o, 8'h21);
    reset = 1'b1;
    #1;
    chk("t8_we_drop", mem_we_o, 0);
    chk("t8_sp", sp_o, 8'hFF);
    chk("t8_busy", busy_o, 0);
    chk("t8_ovf", ovf_o, 0);
    wq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t8_idle_busy", busy_o, 0);
    chk("t8_idle_we", mem_we_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
